// File: rtl/console_pkg.sv
// Shared console types, character codes and the fixed command table used by
// the line parser and its entry comparator.
package console_pkg;

  localparam int MAX_LEN_DEF = 16;
  localparam int CMD_NUM     = 4;
  localparam int CMD_CHARS   = 4;

  typedef logic [2:0] cmd_id_t;

  typedef enum logic [2:0] {
    S_PROMPT,
    S_WAIT_RDY,
    S_COLLECT,
    S_MATCH,
    S_EXEC,
    S_NOCOM
  } state_t;

  typedef enum logic {
    RET_COLLECT,
    RET_PROMPT
  } ret_t;

  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_DEL = 8'h7F;

  // First character sits in the most significant byte; shorter names are
  // padded with 0x00 on the right.
  localparam logic [8*CMD_CHARS-1:0] CMD_TABLE [CMD_NUM] = '{
    "help",
    {"led", 8'h00},
    "stat",
    {"clr", 8'h00}
  };

  // Byte i of table entry k, zero beyond the stored name or table end.
  function automatic logic [7:0] cmd_byte(input cmd_id_t k, input int unsigned i);
    logic [8*CMD_CHARS-1:0] word;
    logic [8*CMD_CHARS-1:0] shifted;
    word = '0;
    for (int e = 0; e < CMD_NUM; e++) begin
      if (k == cmd_id_t'(e)) word = CMD_TABLE[e];
    end
    shifted = '0;
    if (i < CMD_CHARS) shifted = word >> (8 * (CMD_CHARS - 1 - i));
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/cmd_entry_cmp.sv
// Combinational full-width comparison of the line buffer against command
// table entry k; all MAX_LEN bytes must match, including zero padding.
module cmd_entry_cmp
  import console_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic [8*MAX_LEN-1:0] line_flat,
  input  cmd_id_t              k,
  output logic                 hit
);

  logic [MAX_LEN-1:0] byte_eq;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_byte
      assign byte_eq[gi] = (line_flat[8*gi +: 8] == cmd_byte(k, gi));
    end
  endgenerate

  assign hit = &byte_eq;

endmodule

// File: rtl/cmd_line_parser.sv
// Console line editor: collects UART bytes, handles backspace, matches the
// finished line against the command table and sequences prompt requests.
module cmd_line_parser
  import console_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       prompt_ready,
  output logic       init,
  output logic       no_com,
  output logic       cmd_valid,
  output logic [2:0] cmd_id,
  input  logic       cmd_done,
  output logic       rx_drop,
  output logic [4:0] line_len
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_t        state_reg, state_next;
  ret_t          ret_reg, ret_next;
  logic          first_reg, first_next;
  logic [LW-1:0] len_reg, len_next;
  logic          ovf_reg, ovf_next;
  cmd_id_t       k_reg, k_next;
  cmd_id_t       cmd_id_reg, cmd_id_next;
  logic [7:0]    buf_reg [MAX_LEN];

  logic                 buf_wr;
  logic                 buf_clr;
  logic [LW-1:0]        buf_idx;
  logic [7:0]           buf_wdata;
  logic                 init_c;
  logic                 no_com_c;
  logic                 is_print;
  logic                 entry_hit;
  logic [8*MAX_LEN-1:0] line_flat;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (!rst_n || buf_clr) begin
          buf_reg[gi] <= 8'h00;
        end else if (buf_wr && buf_idx == LW'(gi)) begin
          buf_reg[gi] <= buf_wdata;
        end
      end
      assign line_flat[8*gi +: 8] = buf_reg[gi];
    end
  endgenerate

  cmd_entry_cmp #(
    .MAX_LEN (MAX_LEN)
  ) u_cmp (
    .line_flat (line_flat),
    .k         (k_reg),
    .hit       (entry_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= S_PROMPT;
      ret_reg    <= RET_COLLECT;
      first_reg  <= 1'b0;
      len_reg    <= '0;
      ovf_reg    <= 1'b0;
      k_reg      <= '0;
      cmd_id_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ret_reg    <= ret_next;
      first_reg  <= first_next;
      len_reg    <= len_next;
      ovf_reg    <= ovf_next;
      k_reg      <= k_next;
      cmd_id_reg <= cmd_id_next;
    end
  end

  assign is_print = (rx_data >= 8'h20) && (rx_data <= 8'h7E);

  always_comb begin
    state_next  = state_reg;
    ret_next    = ret_reg;
    first_next  = first_reg;
    len_next    = len_reg;
    ovf_next    = ovf_reg;
    k_next      = k_reg;
    cmd_id_next = cmd_id_reg;
    buf_wr      = 1'b0;
    buf_clr     = 1'b0;
    buf_idx     = '0;
    buf_wdata   = 8'h00;
    init_c      = 1'b0;
    no_com_c    = 1'b0;
    case (state_reg)
      S_PROMPT: begin
        if (prompt_ready) begin
          init_c     = 1'b1;
          ret_next   = RET_COLLECT;
          first_next = 1'b1;
          state_next = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        // str_init still shows ready in the cycle after a request.
        if (first_reg) begin
          first_next = 1'b0;
        end else if (prompt_ready) begin
          state_next = (ret_reg == RET_COLLECT) ? S_COLLECT : S_PROMPT;
        end
      end
      S_COLLECT: begin
        if (rx_valid) begin
          if (is_print) begin
            if (len_reg < LW'(MAX_LEN)) begin
              buf_wr    = 1'b1;
              buf_idx   = len_reg;
              buf_wdata = rx_data;
              len_next  = len_reg + 1'b1;
            end else begin
              ovf_next = 1'b1;
            end
          end else if (rx_data == CH_BS || rx_data == CH_DEL) begin
            if (len_reg != '0) begin
              buf_wr   = 1'b1;
              buf_idx  = len_reg - 1'b1;
              len_next = len_reg - 1'b1;
            end
          end else if (rx_data == CH_CR) begin
            if (len_reg == '0 && !ovf_reg) begin
              state_next = S_PROMPT;
            end else begin
              k_next     = '0;
              state_next = S_MATCH;
            end
          end
        end
      end
      S_MATCH: begin
        if (entry_hit && !ovf_reg) begin
          cmd_id_next = k_reg;
          state_next  = S_EXEC;
        end else if (k_reg == cmd_id_t'(CMD_NUM - 1)) begin
          state_next = S_NOCOM;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      S_EXEC: begin
        if (cmd_done) begin
          buf_clr    = 1'b1;
          len_next   = '0;
          ovf_next   = 1'b0;
          state_next = S_PROMPT;
        end
      end
      S_NOCOM: begin
        if (prompt_ready) begin
          no_com_c   = 1'b1;
          buf_clr    = 1'b1;
          len_next   = '0;
          ovf_next   = 1'b0;
          ret_next   = RET_PROMPT;
          first_next = 1'b1;
          state_next = S_WAIT_RDY;
        end
      end
      default: state_next = S_PROMPT;
    endcase
  end

  // Pulses are qualified with rst_n so nothing is requested while in reset.
  assign init      = init_c & rst_n;
  assign no_com    = no_com_c & rst_n;
  assign rx_drop   = rx_valid & (state_reg != S_COLLECT) & rst_n;
  assign cmd_valid = (state_reg == S_EXEC);
  assign cmd_id    = cmd_id_reg;
  assign line_len  = 5'(len_reg);

endmodule

// File: tb/tb_cmd_line_parser.sv
// Self-checking bench for cmd_line_parser: table of console lines plus
// hand-written reset/exec sequences, with an event scoreboard.
module tb_cmd_line_parser;
  import console_pkg::*;

  localparam int ML       = 16;
  localparam int BUSY_CYC = 4;
  localparam int TMO      = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       prompt_ready = 1'b1;
  logic       cmd_done = 1'b0;
  logic       init, no_com, cmd_valid, rx_drop;
  logic [2:0] cmd_id;
  logic [4:0] line_len;

  always #5 clk = ~clk;

  cmd_line_parser #(.MAX_LEN(ML)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .prompt_ready (prompt_ready),
    .init         (init),
    .no_com       (no_com),
    .cmd_valid    (cmd_valid),
    .cmd_id       (cmd_id),
    .cmd_done     (cmd_done),
    .rx_drop      (rx_drop),
    .line_len     (line_len)
  );

  typedef enum int {EV_INIT, EV_NOCOM, EV_CMD, EV_DROP} ev_t;
  typedef struct {
    ev_t        kind;
    logic [2:0] id;
    int         cyc;
  } exp_t;
  typedef struct {
    string      s;
    bit         hit;
    logic [2:0] id;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[16];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rdy_run = 0;
  int   busy = 0;
  bit   req_seen = 1'b0;
  bit   dly = 1'b0;
  bit   cv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input ev_t kind, input logic [2:0] id, input int c);
    exp_t e;
    e.kind = kind;
    e.id   = id;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input ev_t kind, input logic [2:0] id);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event_unexpected: got %s id=%0d at cycle %0d, required none", kind.name(), id, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_CMD && e.id != id) || (e.cyc >= 0 && e.cyc != cyc)) begin
        n_fail++;
        $display("FAIL event_%s: got %s id=%0d cycle %0d, required %s id=%0d cycle %0d",
                 e.kind.name(), kind.name(), id, cyc, e.kind.name(), e.id, e.cyc);
      end else begin
        $display("event %s id=%0d cycle %0d ok", kind.name(), id, cyc);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Output monitor: every prompt/message/command/drop event is scored.
  initial begin
    forever begin
      @(negedge clk);
      if (init || no_com) begin
        req_seen = 1'b1;
        rdy_run  = 0;
        n_checks++;
        if ((init && no_com) || !prompt_ready) begin
          n_fail++;
          $display("FAIL handshake: init=%0b no_com=%0b prompt_ready=%0b, required one pulse with ready=1",
                   init, no_com, prompt_ready);
        end
      end
      if (init) check_event(EV_INIT, 3'd0);
      if (no_com) check_event(EV_NOCOM, 3'd0);
      if (cmd_valid && !cv_prev) check_event(EV_CMD, cmd_id);
      cv_prev = cmd_valid;
      if (rx_drop) check_event(EV_DROP, 3'd0);
    end
  end

  // str_init model: ready falls one cycle after a request, busy a few cycles.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (req_seen) begin
        req_seen = 1'b0;
        dly      = 1'b1;
      end else if (dly) begin
        dly          = 1'b0;
        prompt_ready = 1'b0;
        busy         = BUSY_CYC;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) prompt_ready = 1'b1;
      end
      if (prompt_ready) rdy_run++;
      else rdy_run = 0;
    end
  end

  task automatic cyc_idle();
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    cmd_done = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    cmd_done = 1'b0;
  endtask

  task automatic wait_empty();
    bit ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_events_timeout", int'(ok), 1);
  endtask

  task automatic wait_collect();
    bit ok = 1'b0;
    cyc_idle();
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && rdy_run >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_collect_timeout", int'(ok), 1);
  endtask

  task automatic finish_cmd();
    int u;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    cmd_done = 1'b1;
    u = cyc;
    push_exp(EV_INIT, 3'd0, u + 1);
    cyc_idle();
    @(negedge clk);
    chk("cmd_valid_after_done", int'(cmd_valid), 0);
  endtask

  task automatic run_line(input string s, input bit hit, input logic [2:0] id);
    int len = 0;
    bit ovf = 1'b0;
    int t;
    logic [7:0] b;
    wait_collect();
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      send_byte(b);
      if (b >= 8'h20 && b <= 8'h7E) begin
        if (len < ML) len++;
        else ovf = 1'b1;
      end else if ((b == CH_BS || b == CH_DEL) && len > 0) begin
        len--;
      end
    end
    cyc_idle();
    @(negedge clk);
    chk("line_len", int'(line_len), len);
    send_byte(CH_CR);
    t = cyc;
    if (len == 0 && !ovf) begin
      push_exp(EV_INIT, 3'd0, t + 1);
    end else if (hit) begin
      push_exp(EV_CMD, id, t + 2 + int'(id));
    end else begin
      push_exp(EV_NOCOM, 3'd0, t + 1 + CMD_NUM);
      push_exp(EV_INIT, 3'd0, -1);
    end
    $display("line \"%s\" len=%0d ovf=%0b hit=%0b id=%0d CR at cycle %0d", s, len, ovf, hit, id, t);
    cyc_idle();
    if (hit && !(len == 0 && !ovf)) begin
      wait_empty();
      repeat (2) cyc_idle();
      @(negedge clk);
      chk("cmd_valid_hold", int'(cmd_valid), 1);
      chk("cmd_id_hold", int'(cmd_id), int'(id));
      finish_cmd();
    end
  endtask

  function automatic vec_t mk(input string s, input bit hit, input logic [2:0] id);
    vec_t v;
    v.s   = s;
    v.hit = hit;
    v.id  = id;
    return v;
  endfunction

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    string a17, a20, bs17, s;
    int t;
    a17 = ""; a20 = ""; bs17 = "";
    for (int i = 0; i < 20; i++) a20 = {a20, "a"};
    for (int i = 0; i < 17; i++) begin
      a17  = {a17, "a"};
      bs17 = {bs17, "\010"};
    end
    vecs[0]  = mk("help", 1'b1, 3'd0);
    vecs[1]  = mk("led", 1'b1, 3'd1);
    vecs[2]  = mk("lex\010\010ed", 1'b1, 3'd1);
    vecs[3]  = mk("stat", 1'b1, 3'd2);
    vecs[4]  = mk("clr", 1'b1, 3'd3);
    vecs[5]  = mk("xyz", 1'b0, 3'd0);
    vecs[6]  = mk("hel", 1'b0, 3'd0);
    vecs[7]  = mk("helpx", 1'b0, 3'd0);
    vecs[8]  = mk(a20, 1'b0, 3'd0);
    vecs[9]  = mk("", 1'b0, 3'd0);
    vecs[10] = mk("stat\177\177\177\177clr", 1'b1, 3'd3);
    vecs[11] = mk("\010led", 1'b1, 3'd1);
    vecs[12] = mk("l\012ed", 1'b1, 3'd1);
    vecs[13] = mk("CLR", 1'b0, 3'd0);
    vecs[14] = mk("helpxxxxxxxxxxxx", 1'b0, 3'd0);
    vecs[15] = mk({a17, bs17, "led"}, 1'b0, 3'd0);

    // Power-on reset with str_init already idle.
    repeat (3) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("reset_outputs", int'({init, no_com, cmd_valid, rx_drop}), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_exp(EV_INIT, 3'd0, cyc);
    @(negedge clk);
    chk("reset_len", int'(line_len), 0);
    chk("reset_cmd_valid", int'(cmd_valid), 0);

    for (int i = 0; i < 16; i++) run_line(vecs[i].s, vecs[i].hit, vecs[i].id);

    // Bytes arriving while a command executes are dropped.
    wait_collect();
    s = "stat";
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    send_byte(CH_CR);
    t = cyc;
    push_exp(EV_CMD, 3'd2, t + 4);
    cyc_idle();
    wait_empty();
    send_byte(8'h61);
    push_exp(EV_DROP, 3'd0, cyc);
    send_byte(8'h7F);
    push_exp(EV_DROP, 3'd0, cyc);
    send_byte(CH_CR);
    push_exp(EV_DROP, 3'd0, cyc);
    cyc_idle();
    @(negedge clk);
    chk("exec_cmd_valid", int'(cmd_valid), 1);
    chk("exec_cmd_id", int'(cmd_id), 2);
    chk("exec_line_len", int'(line_len), 4);
    finish_cmd();
    @(negedge clk);
    chk("exec_cleared_len", int'(line_len), 0);

    // cmd_done outside execution is ignored; reset mid-line clears it.
    wait_collect();
    @(posedge clk);
    #1;
    cmd_done = 1'b1;
    s = "abc";
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    cyc_idle();
    @(negedge clk);
    chk("pre_reset_len", int'(line_len), 3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", int'({init, no_com, cmd_valid, rx_drop}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_exp(EV_INIT, 3'd0, cyc);
    @(negedge clk);
    chk("post_reset_len", int'(line_len), 0);
    chk("post_reset_cmd_valid", int'(cmd_valid), 0);
    run_line("clr", 1'b1, 3'd3);

    wait_empty();
    repeat (3) cyc_idle();
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
